// File: rtl/featmap_feeder.sv
// featmap_feeder: holds one unpadded image in a local buffer and, on request,
// streams it out as a zero-padded featmap_size x featmap_size frame, one pixel
// per clock, to the din/din_st port of the convolution layer.
//
// state  | meaning
// IDLE   | waiting for start; the image buffer accepts writes
// FETCH  | one cycle that prefetches buffer word 0 into the read register
// STREAM | emits one padded pixel per cycle, row-major, until the last one
module featmap_feeder #(
    parameter int dwidth       = 16,
    parameter int img_size     = 28,
    parameter int featmap_size = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [9:0]        wr_addr,
    input  logic [dwidth-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic [dwidth-1:0] dout,
    output logic              dout_st,
    output logic              dout_valid,
    output logic              done
);

    localparam int              npix    = img_size * img_size;
    localparam int              cw      = $clog2(featmap_size);
    localparam logic [10:0]     npix_w  = 11'(npix);
    localparam logic [cw-1:0]   last_rc = cw'(featmap_size - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [cw-1:0]     row;
    logic [cw-1:0]     col;
    logic [9:0]        rd_ptr;
    logic [dwidth-1:0] mem [npix];
    logic [dwidth-1:0] rd_data;
    logic              busy_q;

    logic interior;
    logic last_px;
    logic start_acc;
    logic wr_ok;
    logic rd_fire;

    assign busy = busy_q;

    // Decode of the current pixel position and the buffer access strobes.
    // busy stays high for one cycle after the last pixel, so writes are gated
    // by busy while start acceptance only needs the FSM to be back in IDLE;
    // that is what lets a start on the busy-falling edge begin a new frame.
    always_comb begin
        interior  = (row != '0) && (row != last_rc) && (col != '0) && (col != last_rc);
        last_px   = (row == last_rc) && (col == last_rc);
        start_acc = (state == IDLE) && start;
        wr_ok     = wr_en && !busy_q && ({1'b0, wr_addr} < npix_w);
        rd_fire   = (state == FETCH) || ((state == STREAM) && interior);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = STREAM;
            STREAM:  if (last_px) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row/column position of the pixel emitted on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == STREAM) begin
            if (col == last_rc) begin
                col <= '0;
                row <= (row == last_rc) ? '0 : row + cw'(1);
            end else begin
                col <= col + cw'(1);
            end
        end else begin
            row <= '0;
            col <= '0;
        end
    end

    // Buffer read pointer: advances on the prefetch and on each interior pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (state == IDLE) begin
            rd_ptr <= '0;
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + 10'd1;
        end
    end

    // Image buffer with synchronous read; contents survive reset. The read
    // after the final interior pixel would run past the end, so it is skipped.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_fire && ({1'b0, rd_ptr} < npix_w)) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // Registered stream outputs and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            dout       <= '0;
            dout_st    <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy_q <= start_acc || (state != IDLE);
            if (state == STREAM) begin
                dout       <= interior ? rd_data : '0;
                dout_st    <= (row == '0) && (col == '0);
                dout_valid <= 1'b1;
                done       <= last_px;
            end else begin
                dout       <= '0;
                dout_st    <= 1'b0;
                dout_valid <= 1'b0;
                done       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_featmap_feeder.sv
// tb_featmap_feeder: scoreboard bench for featmap_feeder. Stimulus pushes the
// expected padded frame into a queue; a negedge monitor pops and compares.
module tb_featmap_feeder;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic [15:0] dout;
    logic        dout_st;
    logic        dout_valid;
    logic        done;

    featmap_feeder #(.dwidth(16), .img_size(28), .featmap_size(30)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .dout(dout),
        .dout_st(dout_st), .dout_valid(dout_valid), .done(done)
    );

    typedef struct {
        logic [15:0] d;
        logic        st;
        logic        dn;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [784];

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    int          mon_idx = 0;
    int          frame_pix = 0;
    int          st_count = 0;
    int          done_count = 0;
    int          done_idx = -1;
    int          st_last = 0;
    int          st_prev = 0;
    logic [15:0] v31 = '0;
    logic [15:0] v868 = '0;
    int          t_start = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pop and compare every presented pixel; idle cycles must be quiet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_pixel", 32'(dout_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pix_dout", 32'(dout), 32'(e.d));
                    chk("pix_st", 32'(dout_st), 32'(e.st));
                    chk("pix_done", 32'(done), 32'(e.dn));
                end
                if (dout_st) begin
                    st_prev   = st_last;
                    st_last   = cyc;
                    mon_idx   = 0;
                    frame_pix = 1;
                    st_count++;
                end else begin
                    mon_idx++;
                    frame_pix++;
                end
                if (mon_idx == 31) v31 = dout;
                if (mon_idx == 868) v868 = dout;
                if (done) begin
                    done_count++;
                    done_idx = mon_idx;
                end
            end else begin
                chk("idle_quiet", 32'({dout, dout_st, done}), 32'd0);
            end
        end
    end

    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 30; c++) begin
                if (r == 0 || r == 29 || c == 0 || c == 29) e.d = 16'h0000;
                else e.d = model[(r - 1) * 28 + (c - 1)];
                e.st = (r == 0 && c == 0);
                e.dn = (r == 29 && c == 29);
                q.push_back(e);
            end
        end
    endtask

    task automatic write_px(input int addr, input logic [15:0] data, input bit accept);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 10'(addr);
        wr_data = data;
        if (accept) model[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        push_frame();
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || q.size() != 0) && n < 3000);
        if (n >= 3000) chk("idle_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int sc;
        int dc;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({busy, dout, dout_st, dout_valid, done}), 32'd0);
        rst_n = 1'b1;

        // Fill buffer[i] = i+1.
        for (int i = 0; i < 784; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 16'(i + 1);
            model[i] = 16'(i + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Basic frame: latency, spot values, done index, busy fall.
        start_frame();
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done();
        chk("busy_on_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        wait_idle();
        chk("st_latency", 32'(st_last - t_start), 32'd2);
        chk("done_idx", 32'(done_idx), 32'd899);
        chk("idx31", 32'(v31), 32'd1);
        chk("idx868", 32'(v868), 32'd784);
        chk("frame_len", 32'(frame_pix), 32'd900);

        // Writes and start during busy are ignored.
        sc = st_count;
        start_frame();
        repeat (100) @(negedge clk);
        write_px(0, 16'h7FFF, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("single_frame", 32'(st_count - sc), 32'd1);

        // Out-of-range write leaves buffer intact.
        write_px(784, 16'h0005, 1'b0);
        start_frame();
        wait_idle();
        chk("buf0_kept", 32'(v31), 32'd1);
        chk("buf783_kept", 32'(v868), 32'd784);

        // Start and write in the same idle cycle.
        @(negedge clk);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 10'd0;
        wr_data = 16'h8000;
        model[0] = 16'h8000;
        push_frame();
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        wait_idle();
        chk("same_cycle_wr", 32'(v31), 32'h8000);

        // Reset at frame index 400.
        dc = done_count;
        start_frame();
        while (cyc < t_start + 402) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({busy, dout, dout_st, dout_valid, done}), 32'd0);
        chk("abort_len", 32'(frame_pix), 32'd401);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_count - dc), 32'd0);
        start_frame();
        wait_idle();
        chk("restart_len", 32'(frame_pix), 32'd900);
        chk("restart_done_idx", 32'(done_idx), 32'd899);

        // Back-to-back: start on the cycle busy falls.
        start_frame();
        wait_done();
        start = 1'b1;
        push_frame();
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("b2b_spacing", 32'(st_last - st_prev), 32'd902);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
